// File: rtl/seq_pkg.sv
// Shared definitions for the datapath sequencer: widths, opcodes, dp_ctrl
// one-hot encodings and FSM state encoding.
package seq_pkg;

    localparam int unsigned INST_W     = 16;
    localparam int unsigned OPC_W      = 4;
    localparam int unsigned FIELD_W    = 4;
    localparam int unsigned REG_AW_DEF = 4;
    localparam int unsigned CTRL_W_DEF = 6;
    localparam int unsigned CNT_W_DEF  = 16;

    localparam logic [OPC_W-1:0] OP_NOP       = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD       = 4'h1;
    localparam logic [OPC_W-1:0] OP_RSHIFT    = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB       = 4'h3;
    localparam logic [OPC_W-1:0] OP_AND_LSB   = 4'h4;
    localparam logic [OPC_W-1:0] OP_LOAD_IN   = 4'h5;
    localparam logic [OPC_W-1:0] OP_STORE_OUT = 4'h6;
    localparam logic [OPC_W-1:0] OP_HALT      = 4'hF;

    localparam logic [CTRL_W_DEF-1:0] DP_NONE    = 6'b000000;
    localparam logic [CTRL_W_DEF-1:0] DP_ADD     = 6'b000001;
    localparam logic [CTRL_W_DEF-1:0] DP_RSHIFT  = 6'b000010;
    localparam logic [CTRL_W_DEF-1:0] DP_SUB     = 6'b000100;
    localparam logic [CTRL_W_DEF-1:0] DP_AND_LSB = 6'b001000;
    localparam logic [CTRL_W_DEF-1:0] DP_LOAD    = 6'b010000;
    localparam logic [CTRL_W_DEF-1:0] DP_STORE   = 6'b100000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder.
// Ports:
//   op_i        opcode field of an instruction
//   dp_ctrl_o   one-hot Datapath operation select (0 for NOP/HALT/illegal)
//   uses_rs2_o  instruction reads a second source register
//   writes_rd_o instruction writes its result back to rd
//   legal_o     opcode is defined
module seq_decode
    import seq_pkg::*;
(
    input  logic [OPC_W-1:0]      op_i,
    output logic [CTRL_W_DEF-1:0] dp_ctrl_o,
    output logic                  uses_rs2_o,
    output logic                  writes_rd_o,
    output logic                  legal_o
);

    always_comb begin
        dp_ctrl_o   = DP_NONE;
        uses_rs2_o  = 1'b0;
        writes_rd_o = 1'b0;
        legal_o     = 1'b1;
        case (op_i)
            OP_NOP:       ;
            OP_ADD:       begin dp_ctrl_o = DP_ADD;     uses_rs2_o = 1'b1; writes_rd_o = 1'b1; end
            OP_RSHIFT:    begin dp_ctrl_o = DP_RSHIFT;  uses_rs2_o = 1'b1; writes_rd_o = 1'b1; end
            OP_SUB:       begin dp_ctrl_o = DP_SUB;     uses_rs2_o = 1'b1; writes_rd_o = 1'b1; end
            OP_AND_LSB:   begin dp_ctrl_o = DP_AND_LSB; uses_rs2_o = 1'b1; writes_rd_o = 1'b1; end
            OP_LOAD_IN:   begin dp_ctrl_o = DP_LOAD;    writes_rd_o = 1'b1; end
            OP_STORE_OUT: dp_ctrl_o = DP_STORE;
            OP_HALT:      ;
            default:      legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Serial instruction sequencer for the Datapath: accepts one instruction over
// valid/ready, then steps it through READ, EXEC and WRITE, driving register-file
// strobes and the one-hot dp_ctrl word. All outputs are registered.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   inst_valid, inst    instruction handshake input ([15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2)
//   inst_ready          high only while idle
//   addr1, addr2, rd1, rd2   register-file read ports (READ state)
//   wr_addr, wr_en      register-file write port (WRITE state)
//   dp_ctrl             one-hot Datapath select (EXEC state)
//   out_valid           STORE_OUT result present on out_bus
//   done, illegal       single-cycle retire / undefined-opcode pulses
//   halted              HALT executed, frozen until reset
//   retired             wrapping retired-instruction count
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    input  logic [INST_W-1:0] inst,
    output logic              inst_ready,
    output logic [REG_AW-1:0] addr1,
    output logic [REG_AW-1:0] addr2,
    output logic              rd1,
    output logic              rd2,
    output logic [REG_AW-1:0] wr_addr,
    output logic              wr_en,
    output logic [CTRL_W-1:0] dp_ctrl,
    output logic              out_valid,
    output logic              done,
    output logic              illegal,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    state_e               state_q;
    logic [OPC_W-1:0]     op_q;
    logic [FIELD_W-1:0]   rd_q;
    logic                 inst_ready_q;
    logic [REG_AW-1:0]    addr1_q;
    logic [REG_AW-1:0]    addr2_q;
    logic                 rd1_q;
    logic                 rd2_q;
    logic [REG_AW-1:0]    wr_addr_q;
    logic                 wr_en_q;
    logic [CTRL_W-1:0]    dp_ctrl_q;
    logic                 out_valid_q;
    logic                 done_q;
    logic                 illegal_q;
    logic                 halted_q;
    logic [CNT_W-1:0]     retired_q;

    logic [OPC_W-1:0]      dec_op;
    logic [CTRL_W_DEF-1:0] dec_dp_ctrl;
    logic                  dec_uses_rs2;
    logic                  dec_writes_rd;
    logic                  dec_legal;
    logic                  accept;

    // One decoder serves both the incoming instruction (while idle) and the
    // latched one (while busy); only registers are fed from it.
    assign dec_op = (state_q == ST_IDLE) ? inst[15:12] : op_q;
    assign accept = inst_valid && inst_ready_q;

    seq_decode u_decode (
        .op_i        (dec_op),
        .dp_ctrl_o   (dec_dp_ctrl),
        .uses_rs2_o  (dec_uses_rs2),
        .writes_rd_o (dec_writes_rd),
        .legal_o     (dec_legal)
    );

    // Sequencer FSM; strobes for a state are registered on the edge entering it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            rd_q         <= '0;
            inst_ready_q <= 1'b0;
            addr1_q      <= '0;
            addr2_q      <= '0;
            rd1_q        <= 1'b0;
            rd2_q        <= 1'b0;
            wr_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            dp_ctrl_q    <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            halted_q     <= 1'b0;
            retired_q    <= '0;
        end else begin
            addr1_q     <= '0;
            addr2_q     <= '0;
            rd1_q       <= 1'b0;
            rd2_q       <= 1'b0;
            wr_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            dp_ctrl_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    inst_ready_q <= 1'b1;
                    if (accept) begin
                        op_q <= inst[15:12];
                        rd_q <= inst[11:8];
                        if (!dec_legal) begin
                            illegal_q <= 1'b1;
                        end else if (inst[15:12] == OP_NOP) begin
                            done_q    <= 1'b1;
                            retired_q <= retired_q + CNT_W'(1);
                        end else if (inst[15:12] == OP_HALT) begin
                            state_q      <= ST_HALTED;
                            inst_ready_q <= 1'b0;
                            halted_q     <= 1'b1;
                            done_q       <= 1'b1;
                            retired_q    <= retired_q + CNT_W'(1);
                        end else if (inst[15:12] == OP_LOAD_IN) begin
                            // No source operands: skip straight to EXEC.
                            state_q      <= ST_EXEC;
                            inst_ready_q <= 1'b0;
                            dp_ctrl_q    <= CTRL_W'(dec_dp_ctrl);
                        end else begin
                            state_q      <= ST_READ;
                            inst_ready_q <= 1'b0;
                            addr1_q      <= REG_AW'(inst[7:4]);
                            addr2_q      <= REG_AW'(inst[3:0]);
                            rd1_q        <= 1'b1;
                            rd2_q        <= dec_uses_rs2;
                        end
                    end
                end
                ST_READ: begin
                    state_q   <= ST_EXEC;
                    dp_ctrl_q <= CTRL_W'(dec_dp_ctrl);
                    // STORE_OUT has no write-back, so it retires in EXEC.
                    if (!dec_writes_rd) begin
                        out_valid_q <= 1'b1;
                        done_q      <= 1'b1;
                        retired_q   <= retired_q + CNT_W'(1);
                    end
                end
                ST_EXEC: begin
                    if (dec_writes_rd) begin
                        state_q   <= ST_WRITE;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= REG_AW'(rd_q);
                        done_q    <= 1'b1;
                        retired_q <= retired_q + CNT_W'(1);
                    end else begin
                        state_q      <= ST_IDLE;
                        inst_ready_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state_q      <= ST_IDLE;
                    inst_ready_q <= 1'b1;
                end
                ST_HALTED: begin
                    inst_ready_q <= 1'b0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    inst_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign inst_ready = inst_ready_q;
    assign addr1      = addr1_q;
    assign addr2      = addr2_q;
    assign rd1        = rd1_q;
    assign rd2        = rd2_q;
    assign wr_addr    = wr_addr_q;
    assign wr_en      = wr_en_q;
    assign dp_ctrl    = dp_ctrl_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;
    assign illegal    = illegal_q;
    assign halted     = halted_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: each issued instruction pushes its
// expected strobe events (with the cycle they must appear in); a monitor pops
// and compares whenever the DUT shows any strobe.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid;
    logic [15:0] inst;
    logic        inst_ready;
    logic [3:0]  addr1;
    logic [3:0]  addr2;
    logic        rd1;
    logic        rd2;
    logic [3:0]  wr_addr;
    logic        wr_en;
    logic [5:0]  dp_ctrl;
    logic        out_valid;
    logic        done;
    logic        illegal;
    logic        halted;
    logic [15:0] retired;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] exp_ret = 16'h0000;

    typedef struct {
        int          cyc;
        logic        rd1;
        logic        rd2;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic        wr;
        logic [3:0]  wa;
        logic [5:0]  dp;
        logic        ov;
        logic        dn;
        logic        il;
        logic [15:0] ret;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    bit  mon_bad;

    datapath_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_ready (inst_ready),
        .addr1      (addr1),
        .addr2      (addr2),
        .rd1        (rd1),
        .rd2        (rd2),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .dp_ctrl    (dp_ctrl),
        .out_valid  (out_valid),
        .done       (done),
        .illegal    (illegal),
        .halted     (halted),
        .retired    (retired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog cycles=%0d required finish before 90000", cyc);
        $fatal(1, "watchdog");
    end

    function automatic ev_t blank(input int c);
        ev_t e;
        e.cyc = c; e.rd1 = 1'b0; e.rd2 = 1'b0; e.a1 = 4'h0; e.a2 = 4'h0;
        e.wr = 1'b0; e.wa = 4'h0; e.dp = 6'b0; e.ov = 1'b0; e.dn = 1'b0;
        e.il = 1'b0; e.ret = exp_ret;
        return e;
    endfunction

    function automatic logic [5:0] dp_of(input logic [3:0] op);
        case (op)
            4'h1:    return 6'b000001;
            4'h2:    return 6'b000010;
            4'h3:    return 6'b000100;
            4'h4:    return 6'b001000;
            4'h5:    return 6'b010000;
            4'h6:    return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    // Expected event sequence for an instruction accepted on edge number c.
    task automatic model(input logic [15:0] w, input int c);
        ev_t        e;
        logic [3:0] op;
        op = w[15:12];
        case (op)
            4'h0, 4'hF: begin
                exp_ret = exp_ret + 16'd1;
                e = blank(c); e.dn = 1'b1; q.push_back(e);
            end
            4'h1, 4'h2, 4'h3, 4'h4, 4'h6: begin
                e = blank(c); e.rd1 = 1'b1; e.rd2 = (op != 4'h6);
                e.a1 = w[7:4]; e.a2 = w[3:0]; q.push_back(e);
                if (op == 4'h6) begin
                    exp_ret = exp_ret + 16'd1;
                    e = blank(c + 1); e.dp = dp_of(op); e.ov = 1'b1; e.dn = 1'b1;
                    q.push_back(e);
                end else begin
                    e = blank(c + 1); e.dp = dp_of(op); q.push_back(e);
                    exp_ret = exp_ret + 16'd1;
                    e = blank(c + 2); e.wr = 1'b1; e.wa = w[11:8]; e.dn = 1'b1;
                    q.push_back(e);
                end
            end
            4'h5: begin
                e = blank(c); e.dp = dp_of(op); q.push_back(e);
                exp_ret = exp_ret + 16'd1;
                e = blank(c + 1); e.wr = 1'b1; e.wa = w[11:8]; e.dn = 1'b1;
                q.push_back(e);
            end
            default: begin
                e = blank(c); e.il = 1'b1; q.push_back(e);
            end
        endcase
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Present w, wait (bounded) for acceptance; c returns the accept edge number.
    task automatic issue(input logic [15:0] w, input bit use_model, output int c);
        int n;
        n = 0;
        @(negedge clk);
        inst = w;
        inst_valid = 1'b1;
        while (inst_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (inst_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst=%h inst_ready=%b required 1", w, inst_ready);
            inst_valid = 1'b0;
            c = -1;
            return;
        end
        @(posedge clk);
        #1;
        c = cyc;
        inst_valid = 1'b0;
        inst = 16'($urandom);
        if (use_model) model(w, c);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rd1 || rd2 || wr_en || (dp_ctrl != 6'b0) || out_valid || done || illegal) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d rd=%b%b wr=%b dp=%b ov=%b dn=%b il=%b required none",
                             cyc, rd1, rd2, wr_en, dp_ctrl, out_valid, done, illegal);
                end else begin
                    mon_e = q.pop_front();
                    mon_bad = (mon_e.cyc != cyc) || (rd1 !== mon_e.rd1) || (rd2 !== mon_e.rd2) ||
                              (wr_en !== mon_e.wr) || (dp_ctrl !== mon_e.dp) ||
                              (out_valid !== mon_e.ov) || (done !== mon_e.dn) ||
                              (illegal !== mon_e.il) || (retired !== mon_e.ret) ||
                              (mon_e.rd1 && (addr1 !== mon_e.a1 || addr2 !== mon_e.a2)) ||
                              (mon_e.wr && (wr_addr !== mon_e.wa));
                    if (mon_bad) begin
                        errors++;
                        $display("FAIL event actual cyc=%0d rd=%b%b a=%h/%h wr=%b@%h dp=%b ov=%b dn=%b il=%b ret=%h required cyc=%0d rd=%b%b a=%h/%h wr=%b@%h dp=%b ov=%b dn=%b il=%b ret=%h",
                                 cyc, rd1, rd2, addr1, addr2, wr_en, wr_addr, dp_ctrl, out_valid, done, illegal, retired,
                                 mon_e.cyc, mon_e.rd1, mon_e.rd2, mon_e.a1, mon_e.a2, mon_e.wr, mon_e.wa,
                                 mon_e.dp, mon_e.ov, mon_e.dn, mon_e.il, mon_e.ret);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_event cyc=%0d actual none required event at cyc=%0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        int   c;
        ev_t  re;
        rst_n = 1'b0;
        inst_valid = 1'b0;
        inst = 16'h0000;

        // Reset state: every output low, including inst_ready.
        #2;
        chk("reset_outputs",
            {inst_ready, rd1, rd2, wr_en, out_valid, done, illegal, halted,
             dp_ctrl, addr1, addr2, wr_addr, retired}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", inst_ready, 1);

        // ADD r3,r1,r2
        issue(16'h1312, 1'b1, c);
        @(negedge clk);
        chk("add_busy_ready", inst_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("add_retired", retired, 16'd1);

        // AND_LSB r7,r1,r2 then STORE_OUT rs1=5, back to back
        issue(16'h4712, 1'b1, c);
        issue(16'h6050, 1'b1, c);
        @(negedge clk);
        chk("store_busy_ready", inst_ready, 0);
        @(negedge clk);
        chk("store_no_wr", {out_valid, wr_en}, 2'b10);
        @(negedge clk);
        chk("store_back_idle", inst_ready, 1);

        // More ALU patterns and LOAD_IN
        issue(16'h2ABC, 1'b1, c);
        issue(16'h3F01, 1'b1, c);
        issue(16'h5500, 1'b1, c);
        @(negedge clk);
        @(negedge clk);
        chk("load_retired", retired, 16'd6);

        // Illegal opcodes
        issue(16'h9123, 1'b1, c);
        @(negedge clk);
        chk("illegal_ready", inst_ready, 1);
        chk("illegal_retired", retired, 16'd6);
        issue(16'hE000, 1'b1, c);

        // Reset during EXEC of ADD: READ happens, nothing after
        issue(16'h1312, 1'b0, c);
        re = blank(c); re.rd1 = 1'b1; re.rd2 = 1'b1; re.a1 = 4'h1; re.a2 = 4'h2;
        q.push_back(re);
        @(posedge clk);
        #2;
        chk("exec_dp_before_reset", dp_ctrl, 6'b000001);
        #1 rst_n = 1'b0;
        #1;
        chk("midflight_reset_outputs",
            {inst_ready, rd1, rd2, wr_en, out_valid, done, illegal, halted, dp_ctrl, retired}, 64'h0);
        exp_ret = 16'h0000;
        repeat (2) @(negedge clk);
        chk("reset_no_wr", wr_en, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("reset_release_idle", {inst_ready, retired}, {1'b1, 16'h0000});

        // Counter wrap: 65535 NOPs reach FFFF, one more wraps to 0
        for (int i = 0; i < 65535; i++) begin
            issue((i % 7 == 0) ? 16'h0ABC : 16'h0000, 1'b1, c);
        end
        chk("retired_ffff", retired, 16'hFFFF);
        issue(16'h0000, 1'b1, c);
        chk("retired_wrap", retired, 16'h0000);

        // HALT, then hold a valid instruction for 10 cycles
        issue(16'hF000, 1'b1, c);
        @(negedge clk);
        chk("halted_flag", {halted, inst_ready}, 2'b10);
        inst = 16'h1312;
        inst_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halted_ready", inst_ready, 0);
        end
        inst_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("halted_retired", retired, 16'h0001);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
